// File: rtl/spi_byte_frontend.sv
// spi_byte_frontend: SPI mode-0 slave physical layer.
// Synchronises the asynchronous CS/SLCK/MOSI pins into clk and deserialises
// MOSI into bytes, MSB first. It also serialises a response byte onto MISO and
// issues single-clk strobes, so the downstream protocol FSM runs on clk.
//
// Ports:
//   clk         system clock (>= 8x SLCK)
//   rst_n       asynchronous active-low reset
//   CS          chip select, active low (async pin)
//   SLCK        serial clock, idle low (async pin)
//   MOSI        master-out data, sampled on SLCK rise
//   MISO        slave-out data, updated after SLCK fall
//   tx_byte     response byte, sampled when tx_ack pulses
//   tx_ack      pulse: tx_byte loaded into the TX shifter
//   rx_byte     last complete received byte
//   rx_valid    pulse: rx_byte updated
//   frame_abort pulse: CS released with a partial byte
//   busy        frame active
module spi_byte_frontend #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS,
  input  logic              SLCK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_byte,
  output logic              tx_ack,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              frame_abort,
  output logic              busy
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   sclk_d;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic sclk_fall;

  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [CW-1:0]     bit_cnt;
  logic              byte_pending;
  logic              byte_seen;

  // CS synchroniser resets to 0 so that a CS held low through reset is never
  // mistaken for an idle bus; WAIT_IDLE then waits for a genuine high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SLCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    cs_s      = cs_sync[SYNC_STAGES-1];
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    cs_fall   = cs_d & ~cs_s;
    cs_rise   = ~cs_d & cs_s;
    sclk_rise = ~sclk_d & sclk_s;
    sclk_fall = sclk_d & ~sclk_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_IDLE;
      MISO         <= 1'b0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      tx_ack       <= 1'b0;
      frame_abort  <= 1'b0;
      busy         <= 1'b0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      bit_cnt      <= '0;
      byte_pending <= 1'b0;
      byte_seen    <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      tx_ack       <= 1'b0;
      frame_abort  <= 1'b0;
      byte_pending <= 1'b0;

      // Completed byte is published one clk after its final SLCK rise.
      if (byte_pending) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end

      case (state)
        WAIT_IDLE: begin
          busy <= 1'b0;
          MISO <= 1'b0;
          if (cs_s) state <= IDLE;
        end

        IDLE: begin
          busy <= 1'b0;
          MISO <= 1'b0;
          if (cs_fall) begin
            tx_shift  <= tx_byte;
            MISO      <= tx_byte[DATA_W-1];
            tx_ack    <= 1'b1;
            bit_cnt   <= '0;
            byte_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= ACTIVE;
          end
        end

        ACTIVE: begin
          // CS release takes priority over any coincident SLCK edge.
          if (cs_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            MISO    <= 1'b0;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_abort <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt      <= '0;
              byte_pending <= 1'b1;
              byte_seen    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != '0) begin
              tx_shift <= tx_shift << 1;
              MISO     <= tx_shift[DATA_W-2];
            end else if (byte_seen) begin
              tx_shift <= tx_byte;
              MISO     <= tx_byte[DATA_W-1];
              tx_ack   <= 1'b1;
            end
          end
        end

        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
          MISO  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_frontend.sv
module tb_spi_byte_frontend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       CS;
  logic       SLCK;
  logic       MOSI;
  logic       MISO;
  logic [7:0] tx_byte;
  logic       tx_ack;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_abort;
  logic       busy;

  spi_byte_frontend #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .SLCK(SLCK), .MOSI(MOSI), .MISO(MISO),
    .tx_byte(tx_byte), .tx_ack(tx_ack), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_abort(frame_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Response bytes the bench plans to offer, one per tx_ack.
  logic [7:0] tx_plan [256];
  int         tx_idx = 0;
  assign tx_byte = tx_plan[tx_idx[7:0]];

  int         n_valid = 0;
  int         n_ack   = 0;
  int         n_abort = 0;
  int         hi_cnt  = 0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      rx_q.push_back(rx_byte);
    end
    if (tx_ack) begin
      n_ack++;
      tx_idx++;
    end
    if (frame_abort) n_abort++;
    if (busy || MISO) hi_cnt++;
  end

  logic [7:0] fb [4];
  logic [7:0] miso_cap [4];
  logic       busy_ok;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, output logic [7:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = d[7-i];
      #50;
      SLCK = 1'b1;
      #1;
      cap = {cap[6:0], MISO};
      if (!busy) busy_ok = 1'b0;
      #49;
      SLCK = 1'b0;
    end
  endtask

  task automatic run_frame(input int nf, input int np);
    logic [7:0] cap;
    busy_ok = 1'b1;
    CS = 1'b0;
    #60;
    for (int k = 0; k < nf + ((np > 0) ? 1 : 0); k++) begin
      send_bits(fb[k], (k < nf) ? 8 : np, cap);
      miso_cap[k] = cap;
    end
    #60;
    CS = 1'b1;
    #100;
    MOSI = 1'b0;
  endtask

  typedef struct {
    logic [7:0] mosi;
    int         nbits;
    logic [7:0] tx;
    int         exp_valid;
    int         exp_abort;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int v0, a0, k0, h0, base, idx0, nf, np;
    logic [7:0] cap;

    vecs[0] = '{8'hAA, 8, 8'hBB, 1, 0, 8'hAA};
    vecs[1] = '{8'h00, 8, 8'hFF, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 8, 8'h00, 1, 0, 8'hFF};
    vecs[3] = '{8'hA0, 5, 8'h5A, 0, 1, 8'hFF};
    vecs[4] = '{8'h0C, 8, 8'h81, 1, 0, 8'h0C};
    vecs[5] = '{8'h80, 1, 8'h11, 0, 1, 8'h0C};
    vecs[6] = '{8'h69, 8, 8'hC3, 1, 0, 8'h69};

    for (int i = 0; i < 256; i++) tx_plan[i] = 8'h00;
    rst_n = 1'b0; CS = 1'b1; SLCK = 1'b0; MOSI = 1'b0;
    #12;
    check("reset_miso", {31'd0, MISO}, 0);
    check("reset_rx_byte", {24'd0, rx_byte}, 0);
    check("reset_strobes", {29'd0, rx_valid, tx_ack, frame_abort}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    #25;
    rst_n = 1'b1;
    #100;

    // Table-driven single-byte frames
    for (int r = 0; r < 7; r++) begin
      tx_plan[tx_idx[7:0]] = vecs[r].tx;
      fb[0] = vecs[r].mosi;
      v0 = n_valid; a0 = n_abort; k0 = n_ack;
      nf = (vecs[r].nbits == 8) ? 1 : 0;
      np = (vecs[r].nbits == 8) ? 0 : vecs[r].nbits;
      run_frame(nf, np);
      check($sformatf("vec%0d_valid", r), n_valid - v0, vecs[r].exp_valid);
      check($sformatf("vec%0d_abort", r), n_abort - a0, vecs[r].exp_abort);
      check($sformatf("vec%0d_ack", r), n_ack - k0, 1 + nf);
      check($sformatf("vec%0d_rx", r), {24'd0, rx_byte}, {24'd0, vecs[r].exp_rx});
      check($sformatf("vec%0d_busy", r), {31'd0, busy_ok}, 1);
      if (nf == 1) check($sformatf("vec%0d_miso", r), {24'd0, miso_cap[0]}, {24'd0, vecs[r].tx});
    end

    // Two bytes in one frame with a new response after the first ack
    idx0 = tx_idx;
    tx_plan[idx0[7:0]]       = 8'hA5;
    tx_plan[(idx0 + 1) & 255] = 8'h3C;
    fb[0] = 8'h05; fb[1] = 8'h03;
    v0 = n_valid; a0 = n_abort; k0 = n_ack; base = rx_q.size();
    run_frame(2, 0);
    check("two_valid", n_valid - v0, 2);
    check("two_ack", n_ack - k0, 3);
    check("two_abort", n_abort - a0, 0);
    if (rx_q.size() >= base + 2) begin
      check("two_rx0", {24'd0, rx_q[base]}, 32'h05);
      check("two_rx1", {24'd0, rx_q[base+1]}, 32'h03);
    end
    check("two_miso0", {24'd0, miso_cap[0]}, 32'hA5);
    check("two_miso1", {24'd0, miso_cap[1]}, 32'h3C);

    // SLCK activity with CS high must be ignored
    v0 = n_valid; a0 = n_abort; k0 = n_ack; h0 = hi_cnt;
    send_bits(8'hA5, 8, cap);
    send_bits(8'h5A, 8, cap);
    #60;
    check("idle_valid", n_valid - v0, 0);
    check("idle_ack", n_ack - k0, 0);
    check("idle_abort", n_abort - a0, 0);
    check("idle_busy_miso", hi_cnt - h0, 0);

    // Reset in mid-frame with CS held low
    tx_plan[tx_idx[7:0]] = 8'hFF;
    CS = 1'b0;
    #60;
    send_bits(8'hE0, 3, cap);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, busy}, 0);
    check("rstmid_miso", {31'd0, MISO}, 0);
    check("rstmid_rx", {24'd0, rx_byte}, 0);
    #19;
    rst_n = 1'b1;
    v0 = n_valid; k0 = n_ack; h0 = hi_cnt;
    send_bits(8'hFF, 8, cap);
    #60;
    check("rstmid_valid", n_valid - v0, 0);
    check("rstmid_ack", n_ack - k0, 0);
    check("rstmid_busy_miso", hi_cnt - h0, 0);
    CS = 1'b1;
    #100;
    fb[0] = 8'h96;
    tx_plan[tx_idx[7:0]] = 8'h42;
    v0 = n_valid;
    run_frame(1, 0);
    check("rstmid_recover_valid", n_valid - v0, 1);
    check("rstmid_recover_rx", {24'd0, rx_byte}, 32'h96);
    check("rstmid_recover_miso", {24'd0, miso_cap[0]}, 32'h42);

    // CS rise coincident with the 8th SLCK rise
    tx_plan[tx_idx[7:0]] = 8'h77;
    v0 = n_valid; a0 = n_abort; k0 = n_ack;
    CS = 1'b0;
    #60;
    send_bits(8'hFE, 7, cap);
    MOSI = 1'b0;
    #50;
    CS = 1'b1;
    SLCK = 1'b1;
    #50;
    SLCK = 1'b0;
    #100;
    check("coinc_abort", n_abort - a0, 1);
    check("coinc_valid", n_valid - v0, 0);
    check("coinc_ack", n_ack - k0, 1);
    check("coinc_rx_held", {24'd0, rx_byte}, 32'h96);

    // Randomised frames against the byte-level model
    for (int f = 0; f < 20; f++) begin
      nf = $urandom_range(0, 2);
      np = $urandom_range(0, 7);
      for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
      idx0 = tx_idx;
      for (int k = 0; k < 4; k++) tx_plan[(idx0 + k) & 255] = 8'($urandom);
      v0 = n_valid; a0 = n_abort; k0 = n_ack; base = rx_q.size();
      run_frame(nf, np);
      check($sformatf("rnd%0d_valid", f), n_valid - v0, nf);
      check($sformatf("rnd%0d_abort", f), n_abort - a0, (np != 0) ? 1 : 0);
      check($sformatf("rnd%0d_ack", f), n_ack - k0, 1 + nf);
      for (int k = 0; k < nf; k++) begin
        if (rx_q.size() > base + k)
          check($sformatf("rnd%0d_rx%0d", f, k), {24'd0, rx_q[base+k]}, {24'd0, fb[k]});
        check($sformatf("rnd%0d_miso%0d", f, k), {24'd0, miso_cap[k]},
              {24'd0, tx_plan[(idx0 + k) & 255]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
